// File: rtl/dct_block_sequencer_if.sv
// ============================================================================
// Module   : dct_block_sequencer_if
// Brief    : Pixel-read, LUT-select and coefficient-stream bundle of the DCT
//            block sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dct_block_sequencer_if #(
    parameter int PIX_W = 9,
    parameter int COS_W = 32,
    parameter int ACC_W = 32
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic [5:0]              rd_addr;
    logic signed [PIX_W-1:0] pixel_data;
    logic [2:0]              lut_k1;
    logic [2:0]              lut_k2;
    logic [2:0]              lut_n1;
    logic [2:0]              lut_n2;
    logic signed [COS_W-1:0] cos_term;
    logic                    coef_valid;
    logic                    coef_ready;
    logic signed [ACC_W-1:0] coef_data;
    logic [5:0]              coef_idx;

    // The sequencer owns addressing and the coefficient stream.
    modport master (
        input  start, pixel_data, cos_term, coef_ready,
        output busy, done, rd_addr, lut_k1, lut_k2, lut_n1, lut_n2,
               coef_valid, coef_data, coef_idx
    );

    modport slave (
        output start, pixel_data, cos_term, coef_ready,
        input  busy, done, rd_addr, lut_k1, lut_k2, lut_n1, lut_n2,
               coef_valid, coef_data, coef_idx
    );
endinterface

`default_nettype wire

// File: rtl/dct_block_sequencer.sv
// ============================================================================
// Module   : dct_block_sequencer
// Brief    : Walks all 64 (k1,k2) coefficients of an 8x8 DCT, sweeping the
//            pixel buffer and LUT bank, and streams the scaled MAC results.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dct_block_sequencer #(
    parameter int PIX_W     = 9,
    parameter int COS_W     = 32,
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = 8
) (
    input  wire                       clk,
    input  wire                       rst_n,
    dct_block_sequencer_if.master     bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [5:0] c_LAST = 6'd63;

    state_t                  r_state;
    state_t                  w_next;
    logic [5:0]              r_k;
    logic [5:0]              r_n;
    logic signed [COS_W-1:0] r_cos;
    logic                    r_mac_v;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_done;

    logic                    w_start_ok;
    logic                    w_valid;
    logic                    w_hs;
    logic signed [ACC_W-1:0] w_prod;

    // A start landing on the done cycle belongs to the block just finished.
    assign w_start_ok = bus.start && !r_done;
    assign w_valid    = (r_state == S_OUT);
    assign w_hs       = w_valid && bus.coef_ready;

    // Low product bits are identical whatever the intermediate width, so the
    // cast gives plain truncation (or sign extension for a wide accumulator).
    assign w_prod = ACC_W'(bus.pixel_data * r_cos);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_RUN;
            S_RUN:   if (r_n == c_LAST) w_next = S_DRAIN;
            S_DRAIN: w_next = S_OUT;
            S_OUT:   if (w_hs) w_next = (r_k == c_LAST) ? S_IDLE : S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_n     <= '0;
            r_cos   <= '0;
            r_mac_v <= 1'b0;
            r_acc   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_mac_v <= (r_state == S_RUN);
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_k <= '0;
                        r_n <= '0;
                    end
                end
                S_RUN: begin
                    // n wraps to 0 after the 64th sample, ready for the next k.
                    r_cos <= bus.cos_term;
                    r_n   <= r_n + 6'd1;
                end
                S_OUT: begin
                    if (w_hs) begin
                        if (r_k == c_LAST) begin
                            r_done <= 1'b1;
                        end else begin
                            r_k <= r_k + 6'd1;
                        end
                    end
                end
                default: ;
            endcase

            if ((r_state == S_RUN) && (r_n == 6'd0)) begin
                r_acc <= '0;
            end else if (r_mac_v) begin
                r_acc <= r_acc + w_prod;
            end
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.rd_addr    = r_n;
    assign bus.lut_k1     = r_k[5:3];
    assign bus.lut_k2     = r_k[2:0];
    assign bus.lut_n1     = r_n[5:3];
    assign bus.lut_n2     = r_n[2:0];
    assign bus.coef_valid = w_valid;
    assign bus.coef_data  = r_acc >>> FRAC_BITS;
    assign bus.coef_idx   = r_k;

endmodule

`default_nettype wire

// File: tb/tb_dct_block_sequencer.sv
// ============================================================================
// Module   : tb_dct_block_sequencer
// Brief    : Directed self-checking bench with a sync-read pixel RAM and a
//            truncated cos*cos*256 LUT bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dct_block_sequencer;

    localparam int PIX_W     = 9;
    localparam int COS_W     = 32;
    localparam int ACC_W     = 32;
    localparam int FRAC_BITS = 8;

    logic clk;
    logic rst_n;

    dct_block_sequencer_if #(.PIX_W(PIX_W), .COS_W(COS_W), .ACC_W(ACC_W)) bus ();

    dct_block_sequencer #(
        .PIX_W(PIX_W), .COS_W(COS_W), .ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks;
    int n_fail;

    int pix     [64];
    int lut_tab [4096];
    int got_data[64];
    int got_idx [64];
    int n_coef;
    int n_done;
    int busy_cyc;
    int stall_bad;
    bit timed_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.pixel_data <= PIX_W'(pix[bus.rd_addr]);

    always_comb bus.cos_term = lut_tab[{bus.lut_k1, bus.lut_k2, bus.lut_n1, bus.lut_n2}];

    // Truncate toward zero; the small bias keeps exact integers like 128 stable.
    function automatic int lut_val(int k1, int k2, int n1, int n2);
        real pi;
        real v;
        pi = 3.14159265358979323846;
        v  = 256.0 * $cos((2*n1+1)*k1*pi/16.0) * $cos((2*n2+1)*k2*pi/16.0);
        if (v >= 0.0) return $rtoi(v + 1.0e-6);
        return -$rtoi(-v + 1.0e-6);
    endfunction

    function automatic int model_coef(int k);
        longint s;
        s = 0;
        for (int n = 0; n < 64; n++) s += longint'(pix[n]) * longint'(lut_tab[k*64+n]);
        return int'(s >>> FRAC_BITS);
    endfunction

    task automatic fill_pix(input int v);
        for (int i = 0; i < 64; i++) pix[i] = v;
    endtask

    task automatic run_block(input int stall_idx, input int stall_len, input bit spam);
        int left;
        int hold_d;
        int hold_i;
        n_coef = 0; n_done = 0; busy_cyc = 0; stall_bad = 0; timed_out = 1'b1;
        left = stall_len; hold_d = 0; hold_i = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.coef_ready = 1'b1;
        @(negedge clk);
        bus.start = spam;
        for (int c = 0; c < 6000; c++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                n_done++;
                timed_out = 1'b0;
                break;
            end
            bus.coef_ready = 1'b1;
            if (bus.coef_valid && int'(bus.coef_idx) == stall_idx && left > 0) begin
                if (left == stall_len) begin
                    hold_d = bus.coef_data;
                    hold_i = int'(bus.coef_idx);
                end else if (bus.coef_data !== hold_d || int'(bus.coef_idx) !== hold_i) begin
                    stall_bad++;
                end
                bus.coef_ready = 1'b0;
                left--;
            end
            if (bus.coef_valid && bus.coef_ready) begin
                if (n_coef < 64) begin
                    got_data[n_coef] = bus.coef_data;
                    got_idx[n_coef]  = int'(bus.coef_idx);
                end
                n_coef++;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({bus.busy, bus.done, bus.coef_valid, bus.rd_addr, bus.coef_idx,
             bus.lut_k1, bus.lut_k2, bus.lut_n1, bus.lut_n2} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h expected 0", {bus.busy, bus.done, bus.coef_valid,
                     bus.rd_addr, bus.coef_idx, bus.lut_k1, bus.lut_k2, bus.lut_n1, bus.lut_n2});
        end
        n_checks++;
        if (bus.coef_data !== 32'sd0) begin
            n_fail++;
            $display("FAIL reset_coef_data: got %0d expected 0", bus.coef_data);
        end
    endtask

    task automatic test_dc;
        fill_pix(10);
        run_block(-1, 0, 1'b0);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL dc_timeout: got no done expected done"); end
        n_checks++;
        if (n_coef !== 64) begin n_fail++; $display("FAIL dc_count: got %0d expected 64", n_coef); end
        n_checks++;
        if (n_done !== 1) begin n_fail++; $display("FAIL dc_done: got %0d expected 1", n_done); end
        n_checks++;
        if (busy_cyc !== 4224) begin n_fail++; $display("FAIL dc_cycles: got %0d expected 4224", busy_cyc); end
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (got_idx[i] !== i) begin
                n_fail++;
                $display("FAIL dc_idx[%0d]: got %0d expected %0d", i, got_idx[i], i);
            end
            n_checks++;
            if (got_data[i] !== ((i == 0) ? 640 : 0)) begin
                n_fail++;
                $display("FAIL dc_coef[%0d]: got %0d expected %0d", i, got_data[i], (i == 0) ? 640 : 0);
            end
        end
    endtask

    task automatic test_impulse;
        fill_pix(0);
        pix[0] = 100;
        run_block(-1, 0, 1'b0);
        n_checks++;
        if (got_data[0] !== 100) begin n_fail++; $display("FAIL imp_coef0: got %0d expected 100", got_data[0]); end
        n_checks++;
        if (got_data[1] !== 98) begin n_fail++; $display("FAIL imp_coef1: got %0d expected 98", got_data[1]); end
        n_checks++;
        if (got_data[50] !== 35) begin n_fail++; $display("FAIL imp_coef50: got %0d expected 35", got_data[50]); end
    endtask

    task automatic test_neg_impulse;
        fill_pix(0);
        pix[8] = -100;
        run_block(-1, 0, 1'b0);
        n_checks++;
        if (got_data[0] !== -100) begin n_fail++; $display("FAIL neg_coef0: got %0d expected -100", got_data[0]); end
        n_checks++;
        if (got_data[1] !== -99) begin n_fail++; $display("FAIL neg_coef1_floor: got %0d expected -99", got_data[1]); end
        n_checks++;
        if (got_data[50] !== 85) begin n_fail++; $display("FAIL neg_coef50: got %0d expected 85", got_data[50]); end
    endtask

    task automatic test_backpressure;
        fill_pix(10);
        run_block(5, 10, 1'b0);
        n_checks++;
        if (busy_cyc !== 4234) begin n_fail++; $display("FAIL bp_cycles: got %0d expected 4234", busy_cyc); end
        n_checks++;
        if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", stall_bad); end
        n_checks++;
        if (n_coef !== 64) begin n_fail++; $display("FAIL bp_count: got %0d expected 64", n_coef); end
        n_checks++;
        if (got_idx[5] !== 5 || got_data[5] !== 0 || got_data[0] !== 640) begin
            n_fail++;
            $display("FAIL bp_values: got idx5=%0d d5=%0d d0=%0d expected 5 0 640",
                     got_idx[5], got_data[5], got_data[0]);
        end
    endtask

    task automatic test_start_ignored;
        fill_pix(10);
        run_block(-1, 0, 1'b1);
        n_checks++;
        if (n_coef !== 64) begin n_fail++; $display("FAIL spam_count: got %0d expected 64", n_coef); end
        n_checks++;
        if (n_done !== 1) begin n_fail++; $display("FAIL spam_done: got %0d expected 1", n_done); end
        n_checks++;
        if (busy_cyc !== 4224) begin n_fail++; $display("FAIL spam_cycles: got %0d expected 4224", busy_cyc); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL spam_done_cycle_start: got busy=%0b expected 0", bus.busy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL spam_idle[%0d]: got busy=%0b done=%0b expected 0 0", i, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_abort;
        int exp_c[64];
        int hs;
        bit hit;
        for (int i = 0; i < 64; i++) pix[i] = ((i * 37) % 401) - 200;
        for (int k = 0; k < 64; k++) exp_c[k] = model_coef(k);
        hs = 0;
        hit = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.coef_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (c == 7*66 + 30) begin
                hit = 1'b1;
                n_checks++;
                if (bus.rd_addr !== 6'd30 || bus.coef_idx !== 6'd7 || hs !== 7) begin
                    n_fail++;
                    $display("FAIL abort_position: got addr=%0d idx=%0d hs=%0d expected 30 7 7",
                             bus.rd_addr, bus.coef_idx, hs);
                end
                rst_n = 1'b0;
                break;
            end
            if (bus.coef_valid && bus.coef_ready) hs++;
            @(negedge clk);
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL abort_reached: got 0 expected 1"); end
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.coef_valid, bus.rd_addr, bus.coef_idx,
             bus.lut_k1, bus.lut_k2, bus.lut_n1, bus.lut_n2} !== 27'd0 || bus.coef_data !== 32'sd0) begin
            n_fail++;
            $display("FAIL abort_outputs: got ctrl=%h data=%0d expected 0 0", {bus.busy, bus.done,
                     bus.coef_valid, bus.rd_addr, bus.coef_idx, bus.lut_k1, bus.lut_k2,
                     bus.lut_n1, bus.lut_n2}, bus.coef_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_block(-1, 0, 1'b0);
        n_checks++;
        if (n_coef !== 64 || n_done !== 1) begin
            n_fail++;
            $display("FAIL abort_rerun_count: got %0d/%0d expected 64/1", n_coef, n_done);
        end
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (got_data[k] !== exp_c[k]) begin
                n_fail++;
                $display("FAIL abort_rerun_coef[%0d]: got %0d expected %0d", k, got_data[k], exp_c[k]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.start      = 1'b0;
        bus.coef_ready = 1'b0;
        for (int i = 0; i < 64; i++) pix[i] = 0;
        for (int k = 0; k < 64; k++)
            for (int n = 0; n < 64; n++)
                lut_tab[k*64+n] = lut_val(k >> 3, k & 7, n >> 3, n & 7);
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_dc();
        test_impulse();
        test_neg_impulse();
        test_backpressure();
        test_start_ignored();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
